joy_db15_tx: RTL
================

JOY_DB15_TX -- requirements
Module: joy_db15_tx

Device-side end of the DB15 serial joystick link. It emulates the adapter's parallel-load shift register: the host drives JOY_LOAD and JOY_CLK, and this block shifts two joystick words out on JOY_DATA.

Interface
REQ-001 SHALL have parameter WIDTH, default 12, giving the bits per player word.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port joy_clk, input, 1 bit: host shift clock, asynchronous to clk; a rising edge shifts one bit.
REQ-005 SHALL have port joy_load, input, 1 bit: host parallel-load strobe, asynchronous to clk, active-low.
REQ-006 SHALL have port joy_data, output, 1 bit: serial data to the host, active-low (0 = pressed).
REQ-007 SHALL have port joystick1, input, WIDTH bits: player-1 buttons, active-high.
REQ-008 SHALL have port joystick2, input, WIDTH bits: player-2 buttons, active-high.
REQ-009 SHALL have port busy, output, 1 bit: high while a frame is partially shifted.
REQ-010 SHALL have port frame_done, output, 1 bit: one-clk pulse when the final bit of a frame has been shifted out.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag for extra shift clocks.

Function
REQ-012 SHALL pass joy_clk and joy_load through 2-flop synchronizers before any use.
REQ-013 SHALL hold a 2*WIDTH-bit shift register sr and a bit counter cnt (0..2*WIDTH, saturating).
REQ-014 While synchronized load is low, SHALL load sr every clk with the complement of {joystick2, joystick1}, set cnt=0, busy=0 and overrun=0; the frame contents are the inputs sampled on the last clk before load rises.
REQ-015 joy_data SHALL be registered and SHALL equal sr[0] at all times, so bit 0 of joystick1 is presented before the first shift.
REQ-016 On a synchronized joy_clk rising edge with load high, SHALL shift sr right with 1 filled into the MSB and increment cnt.
REQ-017 Bit order on the wire SHALL be joystick1[0]..joystick1[WIDTH-1], then joystick2[0]..joystick2[WIDTH-1].
REQ-018 After 2*WIDTH shifts, joy_data SHALL read 1 (idle, nothing pressed) for all further shifts.
REQ-019 frame_done SHALL pulse for exactly one clk in the cycle cnt goes from 2*WIDTH-1 to 2*WIDTH.
REQ-020 busy SHALL be 1 when 0 < cnt < 2*WIDTH and load is high, and 0 otherwise.
REQ-021 A joy_clk rising edge while cnt==2*WIDTH SHALL set overrun to 1, and it SHALL stay set until the next load.
REQ-022 When a joy_clk edge and load low coincide, load SHALL win and the edge SHALL be discarded.
REQ-023 If load falls mid-frame, the frame SHALL be aborted and restarted per REQ-014, with no frame_done.
REQ-024 Latency from a joy_clk pin edge to the updated joy_data SHALL be 3 clk cycles: 2 synchronizer stages plus 1 register stage.
REQ-025 The synchronizers SHALL treat a joy_clk pulse narrower than 2 clk periods as undefined; the host guarantees at least 4 clk periods high and 4 low.

Reset
REQ-026 Asserting reset SHALL asynchronously set sr to all 1s, cnt=0, joy_data=1, busy=0, frame_done=0, overrun=0, and the synchronizer flops to joy_clk=0 and joy_load=1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release, shifting resumes only after a fresh load.
REQ-028 After reset release, a joy_clk edge with no prior load SHALL shift out 1s and advance cnt.

Configuration
REQ-029 Macro JOY_DB15_TX_CLK_FILTER_EN SHALL control joy_clk deglitching.
REQ-030 With the macro defined, a synchronized joy_clk edge SHALL be accepted only after the new level has been stable for 2 further clk cycles; a shorter glitch is ignored, and REQ-024 latency becomes 5 clk.
REQ-031 Without the macro, edges SHALL be taken directly from the synchronized level per REQ-016, with 3 clk latency.

Verification
REQ-032 Set joystick1=12'h001, joystick2=12'h800, pulse load, apply 24 clocks -> joy_data reads 0 at bit 0 and bit 23, 1 at all others; frame_done pulses once, 3 clk after the 24th edge.
REQ-033 After a full frame, apply 3 extra joy_clk edges -> joy_data stays 1, overrun=1; the next load clears overrun to 0.
REQ-034 Apply 10 shifts, then drop load, then 24 shifts -> full frame is correct; only one frame_done, with busy=1 during shifts 1..23.
REQ-035 Assert reset after 5 shifts -> joy_data=1 and busy=0 immediately, without waiting for a clk edge.
REQ-036 Drive a 1-clk-wide high glitch on joy_clk with the macro defined -> cnt unchanged; without the macro -> behaviour not checked (host-timing violation per REQ-025).

Source files
------------

// File: rtl/joy_db15_tx.sv
// -----------------------------------------------------------------------------
// joy_db15_tx
//   Device side of the DB15 serial joystick link. Emulates the adapter's
//   parallel-load shift register: the host pulses joy_load (active-low) to
//   capture both player words, then clocks them out with joy_clk rising edges.
//
//   Optional build macro: JOY_DB15_TX_CLK_FILTER_EN
//     When defined, a synchronized joy_clk level change is accepted only after
//     it has held for 2 further clk cycles (pin-to-data latency 5 clk instead
//     of 3), which rejects short glitches on the cable.
//
// Ports
//   clk          system clock, all state on its rising edge
//   reset        asynchronous, active-high
//   joy_clk      host shift clock (async to clk), rising edge shifts one bit
//   joy_load     host load strobe (async to clk), active-low
//   joy_data     serial data to host, active-low (0 = pressed)
//   joystick1/2  player button words, active-high, WIDTH bits each
//   busy         a frame is partially shifted
//   frame_done   one-clk pulse as the last frame bit is shifted out
//   overrun      sticky: joy_clk edge seen after the frame was exhausted
// -----------------------------------------------------------------------------
module joy_db15_tx #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             joy_clk,
  input  logic             joy_load,
  output logic             joy_data,
  input  logic [WIDTH-1:0] joystick1,
  input  logic [WIDTH-1:0] joystick2,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);

  localparam int NB = 2 * WIDTH;
  localparam int CW = $clog2(NB + 1);

  // 2-flop synchronizers; load idles high so reset looks like "not loading"
  logic clk_s1_q, clk_s2_q;
  logic load_s1_q, load_s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q  <= 1'b0;
      clk_s2_q  <= 1'b0;
      load_s1_q <= 1'b1;
      load_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= joy_clk;
      clk_s2_q  <= clk_s1_q;
      load_s1_q <= joy_load;
      load_s2_q <= load_s1_q;
    end
  end

  logic shift_edge;

`ifdef JOY_DB15_TX_CLK_FILTER_EN
  // clk_filt_q is the accepted joy_clk level. A differing synchronized level
  // must persist while stab counts 0,1,2 before it is taken; any return to the
  // accepted level restarts the count.
  logic       clk_filt_q, clk_filt_d;
  logic [1:0] stab_q, stab_d;

  always_comb begin
    clk_filt_d = clk_filt_q;
    stab_d     = 2'd0;
    shift_edge = 1'b0;
    if (clk_s2_q != clk_filt_q) begin
      if (stab_q == 2'd2) begin
        clk_filt_d = clk_s2_q;
        shift_edge = clk_s2_q;
      end else begin
        stab_d = 2'(stab_q + 2'd1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_filt_q <= 1'b0;
      stab_q     <= 2'd0;
    end else begin
      clk_filt_q <= clk_filt_d;
      stab_q     <= stab_d;
    end
  end
`else
  logic clk_prev_q;

  assign shift_edge = clk_s2_q & ~clk_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) clk_prev_q <= 1'b0;
    else       clk_prev_q <= clk_s2_q;
  end
`endif

  logic [NB-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovr_q, ovr_d;
  logic          fd_q, fd_d;

  // Load has priority over a coincident shift edge. Shifting past the end of
  // the frame keeps feeding 1s (idle) and flags overrun; cnt saturates.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    ovr_d = ovr_q;
    fd_d  = 1'b0;
    if (!load_s2_q) begin
      sr_d  = ~{joystick2, joystick1};
      cnt_d = '0;
      ovr_d = 1'b0;
    end else if (shift_edge) begin
      sr_d = {1'b1, sr_q[NB-1:1]};
      if (cnt_q == CW'(NB)) ovr_d = 1'b1;
      else                  cnt_d = CW'(cnt_q + 1'b1);
      if (cnt_q == CW'(NB - 1)) fd_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q  <= '1;
      cnt_q <= '0;
      ovr_q <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
      fd_q  <= fd_d;
    end
  end

  // sr_q is itself the output register, so data follows a shift with no
  // extra stage and reset drives the pin high immediately.
  assign joy_data   = sr_q[0];
  assign frame_done = fd_q;
  assign overrun    = ovr_q;
  assign busy       = load_s2_q && (cnt_q != '0) && (cnt_q < CW'(NB));

endmodule
